// File: rtl/mnist_pkg.sv
// Shared types and default sizes for the MNIST input datapath.
package mnist_pkg;

  localparam int unsigned PIXEL_WIDTH = 8;
  localparam int unsigned NUM_PIXELS  = 784;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/beat_counter.sv
// Modulo-NUM_REGS beat counter with increment enable and a wrap flag.
module beat_counter #(
  parameter int unsigned NUM_REGS = 784
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inc,
  output logic [$clog2(NUM_REGS)-1:0] count,
  output logic                        at_last,
  output logic                        wrap
);

  localparam int unsigned CW = $clog2(NUM_REGS);

  logic [CW-1:0] count_q;

  // Last slot flag and wrap on an increment taken from the last slot.
  always_comb begin
    at_last = (count_q == CW'(NUM_REGS - 1));
    wrap    = inc && at_last;
  end

  // Count register: wraps back to zero after the last slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= wrap ? '0 : count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stream_deserializer.sv
// Serial-to-parallel word collector with a double-buffered, handshaked output vector.
module stream_deserializer
  import mnist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PIXEL_WIDTH,
  parameter int unsigned NUM_REGS   = NUM_PIXELS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [DATA_WIDTH-1:0]       dout [NUM_REGS],
  output logic [$clog2(NUM_REGS)-1:0] o_count
);

  localparam int unsigned CW = $clog2(NUM_REGS);

  logic [CW-1:0]         count;
  logic                  at_last;
  logic                  complete;
  logic                  accept;
  logic                  out_full_q;
  logic [DATA_WIDTH-1:0] collect_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] out_q     [NUM_REGS];

  beat_counter #(
    .NUM_REGS (NUM_REGS)
  ) u_beat_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (accept),
    .count   (count),
    .at_last (at_last),
    .wrap    (complete)
  );

  // A completing beat only stalls while the held vector is not being taken.
  always_comb begin
    o_ready = !at_last || !out_full_q || i_ready;
    accept  = i_valid && o_ready;
  end

  // Collect buffer: no reset, contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (accept) begin
      collect_q[count] <= din;
    end
  end

  // Output buffer: loads the completed vector with the final word merged in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        out_q[i] <= '0;
      end
    end else if (complete) begin
      for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
        out_q[i] <= collect_q[i];
      end
      out_q[NUM_REGS-1] <= din;
    end
  end

  // Held-vector flag: a same-edge completion wins over consumption.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_full_q <= 1'b0;
    end else if (complete) begin
      out_full_q <= 1'b1;
    end else if (out_full_q && i_ready) begin
      out_full_q <= 1'b0;
    end
  end

  assign o_valid = out_full_q;
  assign dout    = out_q;
  assign o_count = count;

endmodule

// File: tb/tb_stream_deserializer.sv
// Self-checking bench for stream_deserializer with NUM_REGS = 4, DATA_WIDTH = 8.
module tb_stream_deserializer;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] din;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] dout [NR];
  logic [1:0]    o_count;

  int total;
  int bad;

  stream_deserializer #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .din     (din),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .dout    (dout),
    .o_count (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ir;
    logic        ordy;
    logic        ov;
    logic [1:0]  cnt;
    logic [31:0] dv;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [31:0] packed_dout();
    return {dout[0], dout[1], dout[2], dout[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic ir);
    @(negedge clk);
    i_valid = v;
    din     = d;
    i_ready = ir;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    i_valid = 1'b0;
    din     = '0;
    i_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model state: words gathered so far, held vector, held flag.
  logic [7:0] m_q [$];
  logic [7:0] m_held [NR];
  bit         m_full;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < int'(NR); i++) m_held[i] = '0;
    m_full = 1'b0;
  endtask

  function automatic logic model_ready(input logic ir);
    return (m_q.size() != NR - 1) || !m_full || ir;
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d, input logic ir);
    bit cons;
    cons = m_full && ir;
    if (v && model_ready(ir)) begin
      m_q.push_back(d);
      if (m_q.size() == NR) begin
        for (int i = 0; i < int'(NR); i++) m_held[i] = m_q[i];
        m_q.delete();
        m_full = 1'b1;
        cons   = 1'b0;
      end
    end
    if (cons) m_full = 1'b0;
  endtask

  initial begin
    int         pulses;
    int         pulse_at [3];
    logic [31:0] got;
    logic [7:0] w;

    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    i_valid = 1'b0;
    din     = '0;
    i_ready = 1'b0;

    // Basic fill, drain, then backpressure with simultaneous complete/consume.
    tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 2'd0, 32'h00000000};
    tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 2'd1, 32'h00000000};
    tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 2'd2, 32'h00000000};
    tbl[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 2'd3, 32'h00000000};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 32'h11223344};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 32'h11223344};
    tbl[6]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 2'd0, 32'h11223344};
    tbl[7]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 2'd1, 32'h11223344};
    tbl[8]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11223344};
    tbl[9]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 2'd3, 32'h11223344};
    tbl[10] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 2'd0, 32'h01020304};
    tbl[11] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 2'd1, 32'h01020304};
    tbl[12] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 2'd2, 32'h01020304};
    tbl[13] = '{1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 2'd3, 32'h01020304};
    tbl[14] = '{1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 2'd3, 32'h01020304};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 32'h05060708};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 32'h05060708};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 32'h05060708};

    do_reset();
    #1;
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_o_ready", 32'(o_ready), 32'd1);
    chk("reset_dout", packed_dout(), 32'h0);
    chk("reset_count", 32'(o_count), 32'd0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].ir);
      chk($sformatf("tbl%0d_o_ready", i), 32'(o_ready), 32'(tbl[i].ordy));
      chk($sformatf("tbl%0d_o_valid", i), 32'(o_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_count", i), 32'(o_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_dout", i), packed_dout(), tbl[i].dv);
    end

    // Back-to-back: 12 words, three one-cycle pulses four cycles apart.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      drive(i < 12, 8'(i + 1), 1'b1);
      chk("b2b_o_ready", 32'(o_ready), 32'd1);
      if (o_valid) begin
        if (pulses < 3) begin
          w = 8'(4 * pulses + 1);
          chk("b2b_dout", packed_dout(), {w, w + 8'd1, w + 8'd2, w + 8'd3});
          pulse_at[pulses] = i;
        end
        pulses++;
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd3);
    for (int p = 0; p < 3 && p < pulses; p++) begin
      chk("b2b_pulse_cycle", 32'(pulse_at[p]), 32'(4 * (p + 1)));
    end

    // Gaps: idle cycles carry 0xFF which must never be captured.
    pulses = 0;
    got    = '0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0 && i < 8) drive(1'b1, 8'(8'h31 + i / 2), 1'b1);
      else                     drive(1'b0, 8'hFF, 1'b1);
      if (o_valid) begin
        pulses++;
        got = packed_dout();
      end
    end
    chk("gap_pulses", 32'(pulses), 32'd1);
    chk("gap_dout", got, 32'h31323334);

    // Hold a vector, start another, then reset asynchronously mid-cycle.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h51 + i), 1'b0);
    drive(1'b1, 8'h61, 1'b0);
    chk("pre_rst_o_valid", 32'(o_valid), 32'd1);
    drive(1'b1, 8'h62, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_o_valid", 32'(o_valid), 32'd0);
    chk("async_rst_o_ready", 32'(o_ready), 32'd1);
    chk("async_rst_dout", packed_dout(), 32'h0);
    chk("async_rst_count", 32'(o_count), 32'd0);
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    got    = '0;
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, 8'(8'hA0 + i), 1'b1);
      if (o_valid) begin
        pulses++;
        got = packed_dout();
      end
    end
    chk("rst_mid_pulses", 32'(pulses), 32'd1);
    chk("rst_mid_dout", got, 32'hA0A1A2A3);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic       ir;
      logic [7:0] d;
      v  = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 2) != 0);
      d  = 8'($urandom);
      drive(v, d, ir);
      chk("rnd_o_ready", 32'(o_ready), 32'(model_ready(ir)));
      chk("rnd_o_valid", 32'(o_valid), 32'(m_full));
      chk("rnd_count", 32'(o_count), 32'(m_q.size()));
      chk("rnd_dout", packed_dout(), {m_held[0], m_held[1], m_held[2], m_held[3]});
      model_step(v, d, ir);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
